// File: rtl/sym_sched.sv
// sym_sched: shares one 2-bit-symbol sequence detector between two requesters.
// Grants LEN-symbol bursts round-robin, clears the detector before each burst,
// streams the grantee's symbols and reports the saturating hit count with a
// one-cycle done pulse.
module sym_sched #(
    parameter int LEN   = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             r,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       sym0,
    input  logic [1:0]       sym1,
    output logic             ack0,
    output logic             ack1,
    output logic             det_x1,
    output logic             det_x0,
    output logic             det_r,
    input  logic             det_z1,
    input  logic             det_z0,
    output logic             done0,
    output logic             done1,
    output logic [CNT_W-1:0] hits,
    output logic             busy
);

    // symbol counter only has to reach LEN-1 (LEN <= 15)
    localparam int SCW = 4;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic             gnt, gnt_nxt;      // current grantee
    logic             gnt_pick;          // round-robin choice in IDLE
    logic             gnt_req;           // grantee still requesting
    logic             last;              // last grantee that reached DONE
    logic [SCW-1:0]   cnt;               // symbols streamed so far
    logic [CNT_W-1:0] acc, acc_nxt;      // hit accumulator
    logic             prev_stream;       // previous cycle was STREAM
    logic             hit;
    logic [1:0]       ack_v, done_v, det_x;

    assign gnt_req  = gnt ? req1 : req0;
    // both requesting: the one not served last; otherwise whoever asks
    assign gnt_pick = (req0 & req1) ? ~last : req1;

    // detector output is one cycle late, so a hit belongs to the burst only
    // when the previous cycle streamed a symbol
    assign hit     = (det_z1 | det_z0) & prev_stream;
    assign acc_nxt = (hit && acc != {CNT_W{1'b1}}) ? acc + CNT_W'(1) : acc;

    assign {ack1, ack0}     = ack_v;
    assign {done1, done0}   = done_v;
    assign {det_x1, det_x0} = det_x;

    // state and grantee registers
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state <= IDLE;
            gnt   <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
        end
    end

    // next state and state-decoded detector/requester controls
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        det_r     = 1'b0;
        det_x     = 2'b00;
        ack_v     = 2'b00;
        done_v    = 2'b00;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                det_r = 1'b1;
                busy  = 1'b0;
                if (req0 | req1) begin
                    state_nxt = CLEAR;
                    gnt_nxt   = gnt_pick;
                end
            end
            CLEAR: begin
                det_r     = 1'b1;
                state_nxt = gnt_req ? STREAM : IDLE;
            end
            STREAM: begin
                det_x      = gnt ? sym1 : sym0;
                ack_v[gnt] = 1'b1;
                if (!gnt_req)
                    state_nxt = IDLE;
                else if (cnt == SCW'(LEN - 1))
                    state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                done_v[gnt] = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // symbol counter, hit accumulator and burst result
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            cnt         <= '0;
            acc         <= '0;
            prev_stream <= 1'b0;
            hits        <= '0;
            last        <= 1'b1;
        end else begin
            prev_stream <= (state == STREAM);
            if (state == CLEAR) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                if (state == STREAM)
                    cnt <= cnt + SCW'(1);
                acc <= acc_nxt;
            end
            // result is captured on the way into DONE (including the DRAIN
            // cycle's hit) so hits is already valid while done is high
            if (state == DRAIN) begin
                hits <= acc_nxt;
                last <= gnt;
            end
        end
    end

endmodule
